// File: rtl/bp_mem_cmd_responder.sv
// Behavioural memory-side responder: accepts one mem command at a time, services it
// from a line-organised array and returns exactly one response after latency_p+1 cycles.
module bp_mem_cmd_responder #(
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned els_p         = 1024,
    parameter int unsigned latency_p     = 2
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [4+3+paddr_width_p+block_width_p-1:0]    mem_cmd_i,
    input  logic                                          mem_cmd_v_i,
    output logic                                          mem_cmd_ready_o,
    output logic [4+3+paddr_width_p+block_width_p-1:0]    mem_resp_o,
    output logic                                          mem_resp_v_o,
    input  logic                                          mem_resp_yumi_i
);

    localparam int unsigned idx_w      = $clog2(els_p);
    localparam int unsigned line_bytes = block_width_p / 8;
    localparam int unsigned sh_w       = $clog2(block_width_p);
    localparam int unsigned cnt_w      = $clog2(latency_p + 2);

    typedef struct packed {
        logic [block_width_p-1:0] data;
        logic [paddr_width_p-1:0] addr;
        logic [2:0]               size;
        logic [3:0]               msg_type;
    } msg_s;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    msg_s               resp_q, resp_d;
    logic               resp_v_q, resp_v_d;

    msg_s               cmd;
    logic [idx_w-1:0]   idx;
    logic               oor;
    logic               accept;
    logic               wr_en;
    logic [block_width_p-1:0] wr_line;
    logic [block_width_p-1:0] mem_q [els_p];

    logic [2:0]               sz;
    logic [5:0]               mask6;
    logic [5:0]               off;
    logic [sh_w-1:0]          shamt;
    logic [block_width_p-1:0] low_mask;
    logic [block_width_p-1:0] line_rd;
    logic [block_width_p-1:0] uc_rd_data;
    logic [block_width_p-1:0] uc_wr_line;

    assign cmd             = mem_cmd_i;
    assign idx             = cmd.addr[6 +: idx_w];
    assign oor             = |cmd.addr[paddr_width_p-1:6+idx_w];
    assign mem_cmd_ready_o = (state_q == S_IDLE) && !reset_i;
    assign accept          = mem_cmd_ready_o && mem_cmd_v_i;
    assign mem_resp_o      = resp_q;
    assign mem_resp_v_o    = resp_v_q;

    // Uncached access: naturally aligned window of 2^min(size,6) bytes within the line
    always_comb begin
        sz       = (cmd.size > 3'd6) ? 3'd6 : cmd.size;
        mask6    = 6'((7'd1 << sz) - 7'd1);
        off      = cmd.addr[5:0] & ~mask6;
        shamt    = sh_w'({off, 3'b000});
        low_mask = '0;
        for (int b = 0; b < int'(line_bytes); b++) begin
            low_mask[8*b +: 8] = (b <= int'(mask6)) ? 8'hFF : 8'h00;
        end
        line_rd    = mem_q[idx];
        uc_rd_data = (line_rd >> shamt) & low_mask;
        uc_wr_line = (line_rd & ~(low_mask << shamt)) | ((cmd.data & low_mask) << shamt);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resp_d   = resp_q;
        resp_v_d = resp_v_q;
        wr_en    = 1'b0;
        wr_line  = uc_wr_line;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    resp_d          = cmd;
                    resp_d.data     = '0;
                    case (cmd.msg_type)
                        4'd0: resp_d.data = oor ? '0 : line_rd;
                        4'd1: begin
                            wr_en   = !oor;
                            wr_line = cmd.data;
                        end
                        4'd2: resp_d.data = oor ? '0 : uc_rd_data;
                        4'd3: wr_en = !oor;
                        default: ;
                    endcase
                    if (latency_p == 0) begin
                        state_d  = S_RESP;
                        resp_v_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = cnt_w'(1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == cnt_w'(latency_p)) begin
                    state_d  = S_RESP;
                    resp_v_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            S_RESP: begin
                if (mem_resp_yumi_i) begin
                    state_d  = S_IDLE;
                    resp_v_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            resp_q   <= '0;
            resp_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            resp_v_q <= resp_v_d;
        end
    end

    // Backing array is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[idx] <= wr_line;
        end
    end

    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> mem_resp_v_o
    );

endmodule

// File: tb/tb_bp_mem_cmd_responder.sv
// Randomized bench for bp_mem_cmd_responder against a byte-level memory model.
module tb_bp_mem_cmd_responder;

    localparam int unsigned PW = 40;
    localparam int unsigned BW = 512;
    localparam int unsigned MW = 4 + 3 + PW + BW;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [MW-1:0] cmd = '0;
    logic          cmd_v = 1'b0;
    logic          cmd_ready;
    logic [MW-1:0] resp;
    logic          resp_v;
    logic          yumi = 1'b0;

    logic [MW-1:0] c0_cmd = '0;
    logic          c0_v = 1'b0;
    logic          c0_ready;
    logic [MW-1:0] c0_resp;
    logic          c0_resp_v;
    logic          c0_yumi = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [BW-1:0] mdl [1024];

    always #5 clk = ~clk;

    bp_mem_cmd_responder #(.paddr_width_p(PW), .block_width_p(BW), .els_p(1024), .latency_p(LAT)) dut (
        .clk_i(clk), .reset_i(reset_i), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v),
        .mem_cmd_ready_o(cmd_ready), .mem_resp_o(resp), .mem_resp_v_o(resp_v),
        .mem_resp_yumi_i(yumi));

    bp_mem_cmd_responder #(.paddr_width_p(PW), .block_width_p(BW), .els_p(1024), .latency_p(0)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .mem_cmd_i(c0_cmd), .mem_cmd_v_i(c0_v),
        .mem_cmd_ready_o(c0_ready), .mem_resp_o(c0_resp), .mem_resp_v_o(c0_resp_v),
        .mem_resp_yumi_i(c0_yumi));

    task automatic chk(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_line();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: response data and array update computed byte by byte
    task automatic model(input logic [3:0] t, input logic [2:0] sz, input logic [PW-1:0] a,
                         input logic [BW-1:0] d, output logic [MW-1:0] r);
        logic [BW-1:0] dout;
        logic [BW-1:0] line_v;
        bit            out_of_range;
        int            line, nb, off;
        out_of_range = (a >> 16) != 0;
        line = int'(a[15:6]);
        nb   = 1 << ((sz > 6) ? 6 : sz);
        off  = int'(a[5:0]) - (int'(a[5:0]) % nb);
        dout = '0;
        if (!out_of_range) begin
            line_v = mdl[line];
            case (t)
                4'd0: dout = line_v;
                4'd1: mdl[line] = d;
                4'd2: for (int k = 0; k < nb; k++) dout[8*k +: 8] = line_v[8*(off+k) +: 8];
                4'd3: begin
                    for (int k = 0; k < nb; k++) line_v[8*(off+k) +: 8] = d[8*k +: 8];
                    mdl[line] = line_v;
                end
                default: ;
            endcase
        end
        r = {dout, a, sz, t};
    endtask

    // One complete command/response exchange on the latency_p=2 instance; caller sits at a negedge
    task automatic xact(input logic [3:0] t, input logic [2:0] sz, input logic [PW-1:0] a,
                        input logic [BW-1:0] d, input int hold, output logic [MW-1:0] got);
        logic [MW-1:0] exp;
        int lat;
        chk("ready_idle", MW'(cmd_ready), MW'(1));
        cmd   = {d, a, sz, t};
        cmd_v = 1'b1;
        @(negedge clk);
        cmd_v = 1'b0;
        cmd   = '0;
        lat   = 1;
        while (!resp_v && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", MW'(lat), MW'(LAT + 1));
        model(t, sz, a, d, exp);
        chk($sformatf("resp_t%0d_a%0h", t, a), resp, exp);
        got = resp;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_v", MW'(resp_v), MW'(1));
            chk("hold_ready", MW'(cmd_ready), MW'(0));
            chk("hold_resp", resp, exp);
        end
        if (resp_v) begin
            yumi = 1'b1;
            @(negedge clk);
            yumi = 1'b0;
            chk("post_yumi_v", MW'(resp_v), MW'(0));
            chk("post_yumi_ready", MW'(cmd_ready), MW'(1));
        end
    endtask

    initial begin : main
        logic [MW-1:0] got;
        logic [BW-1:0] pat;
        logic [BW-1:0] line2;
        logic [3:0]    t;
        logic [PW-1:0] a;
        int            lines [5] = '{0, 1, 2, 3, 1023};
        int            seen;

        repeat (3) @(negedge clk);
        chk("rst_ready", MW'(cmd_ready), MW'(0));
        chk("rst_v", MW'(resp_v), MW'(0));
        chk("rst_resp", resp, '0);
        reset_i = 1'b0;
        #1;
        chk("rst_release_ready", MW'(cmd_ready), MW'(1));
        @(negedge clk);

        // Full-line write then read
        pat = {64{8'hA5}};
        xact(4'd1, 3'd0, PW'('h40), pat, 0, got);
        xact(4'd0, 3'd0, PW'('h40), rand_line(), 0, got);
        chk("rd_pattern", MW'(got[MW-1 -: BW]), MW'(pat));

        // Uncached 4-byte write/read inside line 2
        line2 = rand_line();
        xact(4'd1, 3'd5, PW'('h80), line2, 0, got);
        xact(4'd3, 3'd2, PW'('h84), BW'('hDEADBEEF), 0, got);
        xact(4'd2, 3'd2, PW'('h84), rand_line(), 0, got);
        chk("uc_rd_data", MW'(got[MW-1 -: BW]), MW'(BW'('hDEADBEEF)));
        xact(4'd0, 3'd0, PW'('h80), '0, 0, got);
        line2[32 +: 32] = 32'hDEADBEEF;
        chk("uc_line_merge", MW'(got[MW-1 -: BW]), MW'(line2));

        // Long backpressure
        xact(4'd0, 3'd0, PW'('h40), '0, 20, got);

        // Out of range at line index els_p
        xact(4'd1, 3'd0, PW'('h0), rand_line(), 0, got);
        xact(4'd1, 3'd0, PW'('h10000), rand_line(), 0, got);
        xact(4'd0, 3'd0, PW'('h10000), '0, 0, got);
        chk("oor_rd_zero", MW'(got[MW-1 -: BW]), '0);
        xact(4'd0, 3'd0, PW'('h0), '0, 0, got);

        // Zero-latency instance responds the cycle after accept
        chk("lat0_ready", MW'(c0_ready), MW'(1));
        c0_cmd = {BW'('h1234), PW'('h2c0), 3'd3, 4'd9};
        c0_v   = 1'b1;
        @(negedge clk);
        c0_v = 1'b0;
        chk("lat0_v", MW'(c0_resp_v), MW'(1));
        chk("lat0_resp", c0_resp, {BW'(0), PW'('h2c0), 3'd3, 4'd9});
        c0_yumi = c0_resp_v;
        @(negedge clk);
        c0_yumi = 1'b0;
        chk("lat0_post_v", MW'(c0_resp_v), MW'(0));

        // Reset while waiting aborts the command
        cmd   = {BW'(0), PW'('h40), 3'd0, 4'd0};
        cmd_v = 1'b1;
        @(negedge clk);
        cmd_v = 1'b0;
        reset_i = 1'b1;
        #1;
        chk("abort_v", MW'(resp_v), MW'(0));
        chk("abort_ready", MW'(cmd_ready), MW'(0));
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("abort_idle_ready", MW'(cmd_ready), MW'(1));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_v) seen++;
        end
        chk("abort_no_resp", MW'(seen), MW'(0));

        // Array contents are undefined after reset: re-establish every line used below
        foreach (lines[i]) xact(4'd1, 3'd0, PW'(lines[i] * 64), rand_line(), 0, got);

        for (int n = 0; n < 80; n++) begin
            t = 4'($urandom_range(0, 4));
            if (t == 4'd4) t = 4'($urandom_range(4, 15));
            a = PW'(lines[$urandom_range(0, 4)] * 64 + $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[16 + $urandom_range(0, 23)] = 1'b1;
            xact(t, 3'($urandom), a, rand_line(), $urandom_range(0, 3), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
